tron_mem_sequencer: RTL
=======================

Name: tron_mem_sequencer

Overview:
- Arbitrates the single-port shared memory between instruction fetch and data load/store for the Tron CPU.
- Parametrised successor of the fixed fetch-phase mux/decoder pair.
- Adds configurable data/address width and memory read latency.
- Adds a req/ack handshake, fetch-vs-data priority, and registered instruction and load-data outputs for the controller and datapath.

Parameters:
- DATA_W, 16: memory word and instruction width.
- ADDR_W, 16: memory address width.
- MEM_LAT, 1: cycles from address presented to mem_rdata valid. Legal range 1..7; elaboration error outside it.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc  in  ADDR_W  fetch address from datapath.
- fetch_req  in  1  level request for the next instruction.
- data_req  in  1  level request for a data access.
- data_we  in  1  1 = store, 0 = load; qualifies data_req.
- data_addr  in  ADDR_W  load/store address (regA).
- data_wdata  in  DATA_W  store data (busOutput).
- req_ack  out  1  combinational; a request is accepted this cycle.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_we  out  1  registered memory write enable.
- mem_rdata  in  DATA_W  memory read data.
- instruction  out  DATA_W  instruction register.
- mem_data  out  DATA_W  load data register.
- instr_valid  out  1  one-cycle pulse; instruction updated.
- data_done  out  1  one-cycle pulse; load/store complete.
- fetch_phase  out  1  high while a fetch is in flight.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0; all registered outputs 0 (mem_addr, mem_wdata, mem_we, instruction, mem_data, instr_valid, data_done, fetch_phase). An in-flight transaction is abandoned and mem_we drops without waiting for a clock edge.
- States: IDLE, FWAIT, RWAIT, WRITE.
- Acceptance:
  - Requests are sampled only in IDLE. data_req has priority over fetch_req.
  - req_ack=1 in IDLE whenever either request is high; it acknowledges the winning request.
  - The requester must drop req by the cycle after req_ack. Requests raised while busy are ignored, not queued.
- Fetch accepted in cycle 0:
  - Cycle 1: state=FWAIT, mem_addr=pc (latched), fetch_phase=1, cnt=MEM_LAT.
  - cnt decrements each cycle. In the cycle where cnt==0, mem_rdata is captured into instruction at the cycle end.
  - Next cycle (cycle MEM_LAT+2): state=IDLE, instr_valid=1, fetch_phase=0.
- Load accepted in cycle 0: same timing via RWAIT. mem_addr=data_addr; mem_data is captured; data_done=1 in cycle MEM_LAT+2. fetch_phase stays 0.
- Store accepted in cycle 0:
  - Cycle 1: state=WRITE, mem_addr=data_addr, mem_wdata=data_wdata, mem_we=1 for exactly one cycle.
  - Cycle 2: IDLE, mem_we=0, data_done=1.
- Pulse/completion rules:
  - instr_valid and data_done are high for exactly one cycle, in the IDLE cycle that follows completion.
  - A new request may be accepted in that same cycle (back-to-back, no bubble).
- Register retention: instruction and mem_data hold their value until the next capture of the same kind. A load never alters instruction and vice versa.
- Address holding: mem_addr holds its last value in IDLE. mem_wdata changes only on store acceptance.
- Widths: addresses and data are passed unmodified; no truncation or extension. cnt is 3 bits.

Test Plan:
- Reset mid-FWAIT (MEM_LAT=3, reset at cycle 2) -> all outputs 0 immediately; next fetch_req acked in IDLE; no stale instr_valid.
- MEM_LAT=1, pc=16'h0040, fetch_req at cycle 0, memory returns 16'hA5C3 -> req_ack at cycle 0; mem_addr=0040 and fetch_phase=1 at cycle 1; instr_valid and instruction=A5C3 at cycle 3.
- Store: data_addr=16'h1234, data_wdata=16'hBEEF -> mem_we=1 only in cycle 1 with addr 1234, data BEEF; data_done in cycle 2; instruction unchanged.
- fetch_req and data_req (load, addr 16'h0100, rdata 16'h0007) both high in cycle 0 -> load served first, mem_data=0007, data_done at cycle 3; fetch acked at cycle 3 and completes at cycle 6.
- MEM_LAT=4, DATA_W=32, ADDR_W=24 -> instr_valid exactly 6 cycles after ack; full 32-bit word captured; mem_addr matches 24-bit pc.
- fetch_req raised while busy in WRITE -> no req_ack until IDLE; no double transaction; held request accepted in the data_done cycle.

Source files
------------

// File: rtl/tron_mem_sequencer.sv
// tron_mem_sequencer: arbitrates the single-port shared memory between
// instruction fetch and data load/store. Data access wins over fetch,
// requests are only sampled in IDLE, and the instruction and load-data
// registers each keep their value until their own kind of capture.
module tron_mem_sequencer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              req_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] mem_data,
  output logic              instr_valid,
  output logic              data_done,
  output logic              fetch_phase,
  output logic              busy
);

  // The wait counter is 3 bits wide, so only latencies of 1..7 fit.
  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
    $error("tron_mem_sequencer: MEM_LAT must be in 1..7");
  end

  localparam logic [2:0] LAT3 = 3'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWAIT = 2'd1,
    RWAIT = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] cnt;

  // Acknowledge is combinational so the requester can drop its level
  // request on the very next cycle.
  assign req_ack = (state == IDLE) && (fetch_req || data_req);
  assign busy    = (state != IDLE);

  // Sequencer FSM with all memory-side and result outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      instruction <= '0;
      mem_data    <= '0;
      instr_valid <= 1'b0;
      data_done   <= 1'b0;
      fetch_phase <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      data_done   <= 1'b0;
      mem_we      <= 1'b0;
      case (state)
        IDLE: begin
          if (data_req) begin
            mem_addr <= data_addr;
            if (data_we) begin
              mem_wdata <= data_wdata;
              mem_we    <= 1'b1;
              state     <= WRITE;
            end else begin
              cnt   <= LAT3;
              state <= RWAIT;
            end
          end else if (fetch_req) begin
            mem_addr    <= pc;
            fetch_phase <= 1'b1;
            cnt         <= LAT3;
            state       <= FWAIT;
          end
        end
        FWAIT: begin
          if (cnt == 3'd0) begin
            instruction <= mem_rdata;
            instr_valid <= 1'b1;
            fetch_phase <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RWAIT: begin
          if (cnt == 3'd0) begin
            mem_data  <= mem_rdata;
            data_done <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        WRITE: begin
          data_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
